// File: rtl/ahb_s_mem.sv
// rtl/ahb_s_mem.sv - AHB-Lite memory slave: byte-lane storage, wait states, two-cycle ERROR.
// Optional AHB_S_RANDOM_WAIT_EN: per-beat wait count drawn from a 16-bit LFSR.
module ahb_s_mem #(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int MEM_BYTES         = 1024,
  parameter int WAIT_CYCLES       = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
  output logic [15:0]                  xfer_cnt,
  output logic [7:0]                   err_cnt
);
  localparam int DB = AHB_DATA_WIDTH / 8;
  localparam int LW = $clog2(DB);
  localparam int MW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int AW = AHB_ADDRESS_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d, wait_sel;
  logic [AW-1:0]       addr_q;
  logic                write_q;
  logic [LW-1:0]       lo_q, hi_q, lo_d, hi_d;
  logic [AHB_DATA_WIDTH-1:0] rdata_q, rd_lanes;
  logic [15:0]         xfer_q;
  logic [7:0]          err_q;
  logic [7:0]          size_bytes, hi_w;
  logic                accept, bad;
  logic                unused_ok;
  logic [7:0]          mem [MEM_BYTES];

  function automatic logic lane_hit(input int i, input logic [LW-1:0] lo,
                                    input logic [LW-1:0] hi, input logic [AW-1:0] a);
    logic [AW-1:0] idx;
    idx = {a[AW-1:LW], LW'(i)};
    return (LW'(i) >= lo) && (LW'(i) <= hi) && (idx < AW'(MEM_BYTES));
  endfunction

  function automatic logic [MW-1:0] lane_idx(input int i, input logic [AW-1:0] a);
    logic [AW-1:0] idx;
    idx = {a[AW-1:LW], LW'(i)};
    return idx[MW-1:0];
  endfunction

  assign HREADY   = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign HRESP    = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign xfer_cnt = xfer_q;
  assign err_cnt  = err_q;
  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign accept     = HREADY && HSEL && HTRANS[1];
  assign size_bytes = 8'd1 << HSIZE;
  assign bad        = (HADDR >= AW'(MEM_BYTES)) || (size_bytes > 8'(DB));
  // Upper lane comes from the size-aligned address so unaligned starts stop at the container end.
  assign lo_d = HADDR[LW-1:0];
  assign hi_w = 8'(HADDR[LW-1:0] & ~LW'(size_bytes - 8'd1)) + size_bytes - 8'd1;
  assign hi_d = hi_w[LW-1:0];

`ifdef AHB_S_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    lfsr_q <= 16'hACE1;
    else if (accept) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign wait_sel = 4'(lfsr_q % 16'(WAIT_CYCLES + 1));
`else
  assign wait_sel = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d = S_DATA;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (bad) begin
            state_d = S_ERR1;
          end else if (wait_sel != 4'd0) begin
            state_d = S_WAIT;
            wait_d  = wait_sel;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_comb begin
    rd_lanes = '0;
    for (int i = 0; i < DB; i++) begin
      if (lane_hit(i, lo_q, hi_q, addr_q)) rd_lanes[8*i +: 8] = mem[lane_idx(i, addr_q)];
    end
  end

  assign HRDATA = (state_q == S_DATA && !write_q) ? rd_lanes : rdata_q;

  // Memory has no reset; reset forces S_IDLE so an abandoned beat never commits.
  always_ff @(posedge HCLK) begin
    if (state_q == S_DATA && write_q) begin
      for (int i = 0; i < DB; i++) begin
        if (lane_hit(i, lo_q, hi_q, addr_q)) mem[lane_idx(i, addr_q)] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
      xfer_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        lo_q    <= lo_d;
        hi_q    <= hi_d;
      end
      if (state_q == S_DATA) begin
        xfer_q <= xfer_q + 16'd1;
        if (!write_q) rdata_q <= rd_lanes;
      end
      if (state_q == S_ERR2 && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_ahb_s_mem.sv
// tb/tb_ahb_s_mem.sv - scoreboard bench for ahb_s_mem (zero-wait and two-wait instances).
module tb_ahb_s_mem;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct packed {
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [63:0] wd;
  } cmd_t;

  typedef struct packed {
    logic        chk_rd;
    logic        resp;
    logic [7:0]  waits;
    logic [31:0] addr;
    logic [63:0] rd;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [63:0] HWDATA;
  logic        hready0, hresp0, hready2, hresp2;
  logic [63:0] hrdata0, hrdata2;
  logic [15:0] xfer0, xfer2;
  logic [7:0]  err0, err2;
  int          dut_sel = 0;
  logic        sel0, sel2, b_ready, b_resp;
  logic [63:0] b_rdata;

  cmd_t cmd_q[$];
  exp_t sb_q[$];
  logic [7:0] mdl0 [1024];
  logic [7:0] mdl2 [1024];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  assign sel0    = (dut_sel == 0);
  assign sel2    = (dut_sel == 2);
  assign b_ready = sel2 ? hready2 : hready0;
  assign b_resp  = sel2 ? hresp2  : hresp0;
  assign b_rdata = sel2 ? hrdata2 : hrdata0;

  ahb_s_mem #(.WAIT_CYCLES(0)) u_mem0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0), .xfer_cnt(xfer0), .err_cnt(err0)
  );

  ahb_s_mem #(.WAIT_CYCLES(2)) u_mem2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(hready2), .HRESP(hresp2), .HRDATA(hrdata2), .xfer_cnt(xfer2), .err_cnt(err2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [63:0] wd);
    cmd_t c;
    c.tr = tr; c.wr = wr; c.addr = a; c.sz = sz; c.wd = wd;
    cmd_q.push_back(c);
  endtask

  task automatic drive_next(output cmd_t c);
    if (cmd_q.size() != 0) c = cmd_q.pop_front();
    else c = '0;
    HTRANS = c.tr;
    HWRITE = c.wr;
    HADDR  = c.addr;
    HSIZE  = c.sz;
  endtask

  // Expected outcome of an accepted address phase; the byte model is updated in bus order.
  task automatic push_exp(input cmd_t c);
    exp_t e;
    int sb, lo, hi, base, idx;
    logic bad;
    sb  = 1 << c.sz;
    bad = c.tr[1] && (c.addr >= 32'd1024 || sb > 8);
    e = '0;
    e.addr  = c.addr;
    e.resp  = bad;
    e.waits = bad ? 8'd1 : (c.tr[1] && dut_sel == 2) ? 8'd2 : 8'd0;
    e.chk_rd = c.tr[1] && !bad && !c.wr;
    if (c.tr[1] && !bad) begin
      lo   = int'(c.addr % 8);
      hi   = ((int'(c.addr) / sb) * sb) % 8 + sb - 1;
      base = (int'(c.addr) / 8) * 8;
      for (int i = lo; i <= hi; i++) begin
        idx = base + i;
        if (idx < 1024) begin
          if (c.wr) begin
            if (dut_sel == 2) mdl2[idx] = c.wd[8*i +: 8];
            else              mdl0[idx] = c.wd[8*i +: 8];
          end else begin
            e.rd[8*i +: 8] = (dut_sel == 2) ? mdl2[idx] : mdl0[idx];
          end
        end
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic run_cmds();
    cmd_t cur;
    exp_t e;
    logic dp_v, hr;
    int   lows, cyc;
    dp_v = 1'b0; lows = 0; cyc = 0;
    drive_next(cur);
    while ((dp_v || cur.tr != T_IDLE || cmd_q.size() != 0) && cyc < 300) begin
      @(negedge HCLK);
      hr = b_ready;
      if (dp_v && !hr) begin
        lows++;
        check_eq($sformatf("resp_stall@%0h", sb_q[0].addr), 64'(b_resp), 64'(sb_q[0].resp));
      end
      if (dp_v && hr) begin
        e = sb_q.pop_front();
        check_eq($sformatf("waits@%0h", e.addr), 64'(lows), 64'(e.waits));
        check_eq($sformatf("resp@%0h", e.addr), 64'(b_resp), 64'(e.resp));
        if (e.chk_rd) check_eq($sformatf("rdata@%0h", e.addr), b_rdata, e.rd);
        dp_v = 1'b0;
        lows = 0;
      end
      @(posedge HCLK);
      #1;
      cyc++;
      if (hr) begin
        if (cur.tr != T_IDLE) begin
          push_exp(cur);
          dp_v   = 1'b1;
          HWDATA = cur.wd;
        end
        drive_next(cur);
      end
    end
    check_eq("run_in_budget", 64'(cyc < 300), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    HRESETn = 1'b0; HADDR = '0; HTRANS = T_IDLE; HWRITE = 1'b0;
    HSIZE = '0; HBURST = '0; HWDATA = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_eq("rst_hready", 64'(hready0), 64'd1);
    check_eq("rst_hresp", 64'(hresp0), 64'd0);
    check_eq("rst_hrdata", hrdata0, 64'd0);
    check_eq("rst_xfer", 64'(xfer0), 64'd0);
    check_eq("rst_err", 64'(err0), 64'd0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Zero-wait INCR4 word burst, then read back
    HBURST = 3'b011;
    add(T_NSEQ, 1'b1, 32'd0,  3'd2, 64'h0706050403020100);
    add(T_SEQ,  1'b1, 32'd4,  3'd2, 64'h0706050403020100);
    add(T_SEQ,  1'b1, 32'd8,  3'd2, 64'h0f0e0d0c0b0a0908);
    add(T_SEQ,  1'b1, 32'd12, 3'd2, 64'h0f0e0d0c0b0a0908);
    run_cmds();
    check_eq("incr4_wr_xfer", 64'(xfer0), 64'd4);
    add(T_NSEQ, 1'b0, 32'd0,  3'd2, 64'd0);
    add(T_SEQ,  1'b0, 32'd4,  3'd2, 64'd0);
    add(T_SEQ,  1'b0, 32'd8,  3'd2, 64'd0);
    add(T_SEQ,  1'b0, 32'd12, 3'd2, 64'd0);
    run_cmds();
    check_eq("incr4_rd_xfer", 64'(xfer0), 64'd8);
    check_eq("rdata_hold", hrdata0, 64'h0f0e0d0c_00000000);

    // Single byte write then reads, the first one pipelined right behind the write
    HBURST = 3'b000;
    add(T_NSEQ, 1'b1, 32'd5, 3'd0, 64'h0000A50000000000);
    add(T_NSEQ, 1'b0, 32'd5, 3'd0, 64'd0);
    add(T_NSEQ, 1'b0, 32'd0, 3'd3, 64'd0);
    run_cmds();
    check_eq("byte_xfer", 64'(xfer0), 64'd11);

    // Unaligned starts and read-after-write
    add(T_NSEQ, 1'b1, 32'd16, 3'd3, 64'h8877665544332211);
    add(T_NSEQ, 1'b1, 32'd3,  3'd2, 64'h1122334455667788);
    add(T_NSEQ, 1'b1, 32'd9,  3'd3, 64'hDEADBEEFCAFEF00D);
    add(T_NSEQ, 1'b0, 32'd0,  3'd3, 64'd0);
    add(T_NSEQ, 1'b0, 32'd8,  3'd3, 64'd0);
    run_cmds();
    check_eq("unal_xfer", 64'(xfer0), 64'd16);

    // Error responses: out of range address and oversize transfer
    add(T_NSEQ, 1'b1, 32'd1024, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    add(T_NSEQ, 1'b1, 32'd16,   3'd4, 64'hFFFFFFFFFFFFFFFF);
    add(T_NSEQ, 1'b0, 32'd1024, 3'd2, 64'd0);
    add(T_NSEQ, 1'b0, 32'd16,   3'd3, 64'd0);
    run_cmds();
    check_eq("err_cnt", 64'(err0), 64'd3);
    check_eq("err_xfer", 64'(xfer0), 64'd17);

    // Two-wait instance: INCR8 with a BUSY after the third beat, then read back
    dut_sel = 2;
    HBURST  = 3'b101;
    for (int k = 0; k < 8; k++) begin
      b = 8'h40 + 8'(k);
      add((k == 0) ? T_NSEQ : T_SEQ, 1'b1, 32'(64 + 8 * k), 3'd3, {8{b}});
      if (k == 2) add(T_BUSY, 1'b1, 32'd88, 3'd3, 64'd0);
    end
    run_cmds();
    check_eq("incr8_wr_xfer", 64'(xfer2), 64'd8);
    for (int k = 0; k < 8; k++) add((k == 0) ? T_NSEQ : T_SEQ, 1'b0, 32'(64 + 8 * k), 3'd3, 64'd0);
    run_cmds();
    check_eq("incr8_rd_xfer", 64'(xfer2), 64'd16);

    // Reset during a wait state of a write: nothing commits, outputs clear at once
    HBURST = 3'b000;
    HTRANS = T_NSEQ; HWRITE = 1'b1; HADDR = 32'd64; HSIZE = 3'd3;
    @(posedge HCLK);
    #1;
    HTRANS = T_IDLE;
    HWDATA = 64'h5555555555555555;
    @(negedge HCLK);
    check_eq("mid_wait_hready", 64'(hready2), 64'd0);
    HRESETn = 1'b0;
    #1;
    check_eq("mid_rst_hready", 64'(hready2), 64'd1);
    check_eq("mid_rst_hresp", 64'(hresp2), 64'd0);
    check_eq("mid_rst_hrdata", hrdata2, 64'd0);
    check_eq("mid_rst_xfer", 64'(xfer2), 64'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    add(T_NSEQ, 1'b0, 32'd64, 3'd3, 64'd0);
    run_cmds();
    check_eq("post_rst_xfer", 64'(xfer2), 64'd1);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
